// File: rtl/monolith_perm_arbiter.sv
// Round-robin arbiter sharing one Monolith permutation core among NUM_REQ requesters.
// A watchdog aborts a hung permutation; saturating counters track done/aborted jobs.
module monolith_perm_arbiter #(
    parameter int WORD_WIDTH = 31,
    parameter int STATE_SIZE = 16,
    parameter int NUM_REQ    = 4,
    parameter int TIMEOUT    = 64,
    parameter int IDW        = $clog2(NUM_REQ)
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_REQ-1:0]                         req_valid,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic [NUM_REQ*STATE_SIZE*WORD_WIDTH-1:0]   req_state,
    output logic                                       resp_valid,
    input  logic                                       resp_ready,
    output logic [IDW-1:0]                             resp_id,
    output logic [STATE_SIZE*WORD_WIDTH-1:0]           resp_state,
    output logic                                       resp_error,
    output logic                                       perm_start,
    output logic [STATE_SIZE*WORD_WIDTH-1:0]           perm_state_in,
    input  logic                                       perm_done,
    input  logic [STATE_SIZE*WORD_WIDTH-1:0]           perm_state_out,
    output logic                                       perm_abort,
    output logic [15:0]                                done_count,
    output logic [15:0]                                abort_count
);
    localparam int SW  = STATE_SIZE * WORD_WIDTH;
    localparam int WDW = $clog2(TIMEOUT);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ABORT = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]     state_q, state_d;
    logic [SW-1:0]  buf_q, buf_d;
    logic [IDW-1:0] gnt_q, gnt_d;
    logic [IDW-1:0] last_q, last_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic [15:0]    done_cnt_q, done_cnt_d;
    logic [15:0]    abort_cnt_q, abort_cnt_d;

    logic [SW-1:0]  req_words [NUM_REQ];
    logic [IDW-1:0] win;
    logic           any_valid;
    logic           grant_now;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign req_words[gi] = req_state[gi*SW +: SW];
        assign req_ready[gi] = grant_now && (win == IDW'(gi));
    end

    // Scan from farthest to nearest offset so the nearest valid requester after last wins.
    always_comb begin
        int idx;
        win = '0;
        idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = int'(last_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (req_valid[IDW'(idx)]) win = IDW'(idx);
        end
    end

    assign any_valid = |req_valid;
    assign grant_now = (state_q == S_IDLE) && any_valid && !reset;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wd_d        = wd_q;
        err_d       = err_q;
        done_cnt_d  = done_cnt_q;
        abort_cnt_d = abort_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    buf_d   = req_words[win];
                    gnt_d   = win;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion on the final watchdog cycle still counts as success.
                if (perm_done) begin
                    buf_d = perm_state_out;
                    if (done_cnt_q != 16'hFFFF) done_cnt_d = done_cnt_q + 16'd1;
                    state_d = S_RESP;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    state_d = S_ABORT;
                end else begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            S_ABORT: begin
                buf_d = '0;
                err_d = 1'b1;
                if (abort_cnt_q != 16'hFFFF) abort_cnt_d = abort_cnt_q + 16'd1;
                state_d = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    last_d  = gnt_q;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            buf_q       <= '0;
            gnt_q       <= '0;
            last_q      <= IDW'(NUM_REQ - 1);
            wd_q        <= '0;
            err_q       <= 1'b0;
            done_cnt_q  <= '0;
            abort_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            done_cnt_q  <= done_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign resp_valid    = (state_q == S_RESP);
    assign resp_id       = gnt_q;
    assign resp_state    = buf_q;
    assign resp_error    = err_q;
    assign perm_start    = (state_q == S_ISSUE);
    assign perm_abort    = (state_q == S_ABORT);
    assign perm_state_in = buf_q;
    assign done_count    = done_cnt_q;
    assign abort_count   = abort_cnt_q;
endmodule

// File: tb/tb_monolith_perm_arbiter.sv
// Bench for monolith_perm_arbiter: mock core with programmable latency, directed plus
// random jobs checked against a transaction-level round-robin / timing model.
module tb_monolith_perm_arbiter;
    localparam int WW  = 31;
    localparam int SS  = 16;
    localparam int NR  = 4;
    localparam int TO  = 24;
    localparam int IDW = 2;
    localparam int SW  = WW * SS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*SW-1:0]  req_state;
    logic              resp_valid;
    logic              resp_ready;
    logic [IDW-1:0]    resp_id;
    logic [SW-1:0]     resp_state;
    logic              resp_error;
    logic              perm_start;
    logic [SW-1:0]     perm_state_in;
    logic              perm_done;
    logic [SW-1:0]     perm_state_out;
    logic              perm_abort;
    logic [15:0]       done_count;
    logic [15:0]       abort_count;

    monolith_perm_arbiter #(
        .WORD_WIDTH(WW), .STATE_SIZE(SS), .NUM_REQ(NR), .TIMEOUT(TO), .IDW(IDW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_state(resp_state), .resp_error(resp_error),
        .perm_start(perm_start), .perm_state_in(perm_state_in),
        .perm_done(perm_done), .perm_state_out(perm_state_out),
        .perm_abort(perm_abort), .done_count(done_count), .abort_count(abort_count)
    );

    // Mock core: done arrives core_lat cycles after the start cycle; core_lat==0 hangs.
    int            core_lat = 0;
    int            core_cnt = 0;
    logic [SW-1:0] core_cap = '0;
    logic [SW-1:0] xor_mask = '0;
    logic          spur_done = 1'b0;

    always @(posedge clk) begin
        if (reset || perm_abort) core_cnt <= 0;
        else if (perm_start) begin
            core_cnt <= core_lat;
            core_cap <= perm_state_in;
        end else if (core_cnt > 0) core_cnt <= core_cnt - 1;
    end
    assign perm_done      = (core_cnt == 1) || spur_done;
    assign perm_state_out = core_cap ^ xor_mask;

    int total = 0;
    int bad   = 0;
    int m_last  = NR - 1;
    int m_done  = 0;
    int m_abort = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_v(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        int idx;
        for (int k = 1; k <= NR; k++) begin
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        chk_v("rst_resp_state", resp_state, '0);
        chk("rst_resp_error", 32'(resp_error), 0);
        chk("rst_perm_start", 32'(perm_start), 0);
        chk("rst_perm_abort", 32'(perm_abort), 0);
        chk("rst_done_count", 32'(done_count), 0);
        chk("rst_abort_count", 32'(abort_count), 0);
    endtask

    // Entered and left at posedge+1 with the arbiter idle.
    task automatic run_job(input logic [NR-1:0] v, input int lat, input int hold);
        int w, resp_n, abort_n;
        bit aborted, busy_rdy, unstable;
        logic [SW-1:0] st, exp_st;
        for (int r = 0; r < NR; r++)
            for (int i = 0; i < SS; i++)
                req_state[(r*SS+i)*WW +: WW] = WW'($urandom);
        req_valid  = v;
        core_lat   = lat;
        resp_ready = (hold == 0);
        w  = rr_pick(v, m_last);
        st = req_state[w*SW +: SW];
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 1 << w);
        tick();
        req_valid = NR'($urandom);
        @(negedge clk);
        chk("perm_start", 32'(perm_start), 1);
        chk_v("perm_state_in", perm_state_in, st);
        busy_rdy = 0;
        resp_n   = -1;
        abort_n  = -1;
        for (int n = 2; n < TO + 10; n++) begin
            tick();
            req_valid = NR'($urandom);
            @(negedge clk);
            if (req_ready != '0) busy_rdy = 1;
            if (perm_abort) abort_n = n;
            if (resp_valid) begin
                resp_n = n;
                break;
            end
        end
        aborted = (lat == 0) || (lat > TO);
        exp_st  = aborted ? '0 : (st ^ xor_mask);
        if (aborted) m_abort++;
        else m_done++;
        chk("resp_cycle", resp_n, aborted ? TO + 3 : lat + 2);
        chk("abort_cycle", abort_n, aborted ? TO + 2 : -1);
        chk("busy_req_ready", 32'(busy_rdy), 0);
        chk("resp_id", 32'(resp_id), w);
        chk("resp_error", 32'(resp_error), 32'(aborted));
        chk_v("resp_state", resp_state, exp_st);
        chk("done_count", 32'(done_count), m_done);
        chk("abort_count", 32'(abort_count), m_abort);
        if (hold > 0) begin
            unstable = 0;
            for (int h = 0; h < hold; h++) begin
                tick();
                req_valid = NR'($urandom);
                @(negedge clk);
                if (!resp_valid || int'(resp_id) != w || resp_state !== exp_st ||
                    resp_error !== aborted || req_ready != '0) unstable = 1;
            end
            chk("hold_stable", 32'(unstable), 0);
            tick();
            resp_ready = 1'b1;
            @(negedge clk);
            chk("hs_valid", 32'(resp_valid), 1);
        end
        tick();
        resp_ready = 1'b0;
        req_valid  = '0;
        m_last = w;
        $display("job req=%b win=%0d lat=%0d hold=%0d err=%0d", v, w, lat, hold, aborted);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int r, lat;
        for (int i = 0; i < SS; i++) xor_mask[i*WW] = 1'b1;
        reset = 1'b1; req_valid = '0; resp_ready = 1'b0; req_state = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        tick();

        // single request, round robin from reset state of last
        run_job(4'b0100, 20, 0);
        repeat (6) run_job(4'b1111, $urandom_range(1, 6), 0);
        // backpressure
        run_job(4'b0110, 9, 10);
        // watchdog then recovery
        run_job(4'b0001, 0, 0);
        run_job(4'b0001, 5, 0);
        // done coincides with final watchdog cycle, and one cycle too late
        run_job(4'b1000, TO, 0);
        run_job(4'b1000, TO + 1, 0);

        for (int j = 0; j < 20; j++) begin
            r = $urandom_range(0, 9);
            if (r == 0) lat = 0;
            else if (r == 1) lat = TO + $urandom_range(0, 2);
            else lat = $urandom_range(1, TO);
            run_job(NR'($urandom_range(1, 15)), lat, $urandom_range(0, 3));
        end

        // reset while the core is busy
        req_valid = 4'b0010; core_lat = 0; resp_ready = 1'b0;
        @(negedge clk);
        chk("wait_req_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("wait_perm_start", 32'(perm_start), 1);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last = NR - 1; m_done = 0; m_abort = 0;
        @(negedge clk);
        check_reset_outputs();
        $display("reset during wait applied");
        spur_done = 1'b1;
        tick();
        spur_done = 1'b0;
        @(negedge clk);
        chk("spur_done_count", 32'(done_count), 0);
        chk("spur_perm_start", 32'(perm_start), 0);
        chk("spur_resp_valid", 32'(resp_valid), 0);
        tick();
        run_job(4'b1111, 7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
